// File: rtl/whack_a_mole_pkg.sv
// whack_a_mole_pkg: shared FSM encoding and helpers for the whack-a-mole game.
// Provides the player state enum, ms->clock conversion and a lowest-set-bit encoder.
package whack_a_mole_pkg;

    localparam int MAX_HOLES = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        REACT   = 3'd2,
        WHACK   = 3'd3,
        HOLDOFF = 3'd4
    } player_state_e;

    function automatic int ms_to_clks(input int ms, input int clks_per_ms);
        return ms * clks_per_ms;
    endfunction

    // One-hot of the lowest set bit; all zeros when v is zero.
    function automatic logic [MAX_HOLES-1:0] lowest_set(
        input logic [MAX_HOLES-1:0] v
    );
        return v & (~v + MAX_HOLES'(1));
    endfunction

endpackage

// File: rtl/auto_player_counter.sv
// ms_delay_counter: loadable down-counter with a one-cycle done pulse.
// Ports: clk, rst (sync, high), load, value[W], done. The load cycle counts as
// the first cycle, so done is high in the value-th cycle after (and including) load.
module ms_delay_counter
    import whack_a_mole_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/auto_player.sv
// auto_player: demo-mode player that whacks moles after a human-like delay.
// Ports: clk, rst, enable, mole_positions in; switches, whack_strobe, whack_count out.
// Optional AUTO_PLAYER_LFSR_JITTER_EN adds LFSR-driven reaction jitter.
module auto_player
    import whack_a_mole_pkg::*;
#(
    parameter int NUM_HOLES   = 18,
    parameter int CLKS_PER_MS = 50000,
    parameter int REACTION_MS = 300,
    parameter int SETTLE_MS   = 150,
    parameter int MISS_EVERY  = 5,
    parameter int JITTER_MS   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_HOLES-1:0] mole_positions,
    output logic [NUM_HOLES-1:0] switches,
    output logic                 whack_strobe,
    output logic [15:0]          whack_count
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_WAIT    = WAIT;
    localparam logic [2:0] S_REACT   = REACT;
    localparam logic [2:0] S_WHACK   = WHACK;
    localparam logic [2:0] S_HOLDOFF = HOLDOFF;

    localparam int REACT_CLKS  = ms_to_clks(REACTION_MS, CLKS_PER_MS);
    localparam int SETTLE_CLKS = ms_to_clks(SETTLE_MS, CLKS_PER_MS);
`ifdef AUTO_PLAYER_LFSR_JITTER_EN
    localparam int JITTER_MAX  = (JITTER_MS - 1) * CLKS_PER_MS;
`else
    localparam int JITTER_MAX  = 0 * JITTER_MS;
`endif
    localparam int REACT_MAX   = REACT_CLKS + JITTER_MAX;
    localparam int MAX_CLKS    = (REACT_MAX > SETTLE_CLKS) ?
                                 REACT_MAX : SETTLE_CLKS;
    localparam int CW          = $clog2(MAX_CLKS) + 1;

    localparam logic [15:0] MISS_DUE =
        16'((MISS_EVERY == 0) ? 0 : MISS_EVERY - 1);

    logic [2:0]           state, state_nx;
    logic [NUM_HOLES-1:0] prev_moles, whacked, pending;
    logic [NUM_HOLES-1:0] empty_holes, hit_bit, miss_bit, tgt;
    logic [15:0]          miss_cnt;
    logic [CW-1:0]        load_val, react_val;
    logic                 change, done, load, fire;
    logic                 miss_due, is_miss;

    assign change = (mole_positions != prev_moles);

    // A fresh pattern invalidates the whacked mask in the same cycle.
    assign pending = change ? mole_positions : (mole_positions & ~whacked);

    assign empty_holes = ~mole_positions;
    assign hit_bit  = NUM_HOLES'(lowest_set(MAX_HOLES'(pending)));
    assign miss_bit = NUM_HOLES'(lowest_set(MAX_HOLES'(empty_holes)));

    // A miss turn with no empty hole falls back to a hit and stays due.
    assign miss_due = (MISS_EVERY != 0) && (miss_cnt == MISS_DUE);
    assign is_miss  = miss_due && (empty_holes != '0);
    assign tgt      = is_miss ? miss_bit : hit_bit;

`ifdef AUTO_PLAYER_LFSR_JITTER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign react_val = CW'(REACT_CLKS +
                           (int'(lfsr) % JITTER_MS) * CLKS_PER_MS);
`else
    assign react_val = CW'(REACT_CLKS);
`endif

    ms_delay_counter #(
        .W(CW)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .value(load_val),
        .done (done)
    );

    // The whack itself is committed on the edge into WHACK, so the
    // switch toggle and strobe are both visible during the WHACK cycle.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        load_val = react_val;
        fire     = 1'b0;
        if (!enable) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: state_nx = S_WAIT;
                S_WAIT: begin
                    if (pending != '0) begin
                        load     = 1'b1;
                        state_nx = S_REACT;
                    end
                end
                S_REACT: begin
                    if (change) begin
                        load = 1'b1;
                    end else if (done) begin
                        if (pending != '0) begin
                            fire     = 1'b1;
                            state_nx = S_WHACK;
                        end else begin
                            state_nx = S_WAIT;
                        end
                    end
                end
                S_WHACK: begin
                    load     = 1'b1;
                    load_val = CW'(SETTLE_CLKS);
                    state_nx = S_HOLDOFF;
                end
                S_HOLDOFF: begin
                    if (change) begin
                        load     = 1'b1;
                        state_nx = S_REACT;
                    end else if (done) begin
                        if (pending != '0) begin
                            fire     = 1'b1;
                            state_nx = S_WHACK;
                        end else begin
                            state_nx = S_WAIT;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            prev_moles   <= '0;
            whacked      <= '0;
            switches     <= '0;
            whack_strobe <= 1'b0;
            whack_count  <= '0;
            miss_cnt     <= '0;
        end else begin
            state        <= state_nx;
            prev_moles   <= mole_positions;
            whack_strobe <= fire;
            if (!enable || (change && state != S_IDLE)) begin
                whacked <= '0;
            end else if (fire && !is_miss) begin
                whacked <= whacked | tgt;
            end
            if (fire) begin
                switches <= switches ^ tgt;
                if (whack_count != 16'hFFFF) begin
                    whack_count <= whack_count + 16'd1;
                end
                if (is_miss) begin
                    miss_cnt <= '0;
                end else if (MISS_EVERY != 0 && !miss_due) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player: scoreboard bench for auto_player (three MISS_EVERY variants).
// Expected whacks are queued at stimulus time and popped on each whack_strobe.
module tb_auto_player;

    typedef struct {
        int          cyc;
        logic [17:0] sw;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en0 = 1'b0, en3 = 1'b0, en1 = 1'b0;
    logic [17:0] moles = '0;
    logic [17:0] sw0, sw3, sw1;
    logic        st0, st3, st1;
    logic [15:0] c0, c3, c1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q3[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    auto_player #(
        .NUM_HOLES(18), .CLKS_PER_MS(2), .REACTION_MS(3),
        .SETTLE_MS(2), .MISS_EVERY(0), .JITTER_MS(64)
    ) u0 (
        .clk(clk), .rst(rst), .enable(en0), .mole_positions(moles),
        .switches(sw0), .whack_strobe(st0), .whack_count(c0)
    );

    auto_player #(
        .NUM_HOLES(18), .CLKS_PER_MS(2), .REACTION_MS(3),
        .SETTLE_MS(2), .MISS_EVERY(3), .JITTER_MS(64)
    ) u3 (
        .clk(clk), .rst(rst), .enable(en3), .mole_positions(moles),
        .switches(sw3), .whack_strobe(st3), .whack_count(c3)
    );

    auto_player #(
        .NUM_HOLES(18), .CLKS_PER_MS(2), .REACTION_MS(3),
        .SETTLE_MS(2), .MISS_EVERY(1), .JITTER_MS(64)
    ) u1 (
        .clk(clk), .rst(rst), .enable(en1), .mole_positions(moles),
        .switches(sw1), .whack_strobe(st1), .whack_count(c1)
    );

    always @(negedge clk) begin
        exp_t e;
        if (st0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL u0_unexpected_whack cyc=%0d sw=%h", cyc, sw0);
            end else begin
                e = q0.pop_front();
                if (cyc !== e.cyc || sw0 !== e.sw || c0 !== e.cnt) begin
                    errors++;
                    $display("FAIL u0_whack got cyc=%0d sw=%h cnt=%0d need cyc=%0d sw=%h cnt=%0d",
                             cyc, sw0, c0, e.cyc, e.sw, e.cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (st3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL u3_unexpected_whack cyc=%0d sw=%h", cyc, sw3);
            end else begin
                e = q3.pop_front();
                if (cyc !== e.cyc || sw3 !== e.sw || c3 !== e.cnt) begin
                    errors++;
                    $display("FAIL u3_whack got cyc=%0d sw=%h cnt=%0d need cyc=%0d sw=%h cnt=%0d",
                             cyc, sw3, c3, e.cyc, e.sw, e.cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (st1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_unexpected_whack cyc=%0d sw=%h", cyc, sw1);
            end else begin
                e = q1.pop_front();
                if (cyc !== e.cyc || sw1 !== e.sw || c1 !== e.cnt) begin
                    errors++;
                    $display("FAIL u1_whack got cyc=%0d sw=%h cnt=%0d need cyc=%0d sw=%h cnt=%0d",
                             cyc, sw1, c1, e.cyc, e.sw, e.cnt);
                end
            end
        end
    end

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; en0 = 1'b0; en3 = 1'b0; en1 = 1'b0; moles = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() + q3.size() + q1.size()) != 0 && n < 120) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ((q0.size() + q3.size() + q1.size()) != 0) begin
            errors++;
            $display("FAIL %s_timeout queued=%0d need 0", name,
                     q0.size() + q3.size() + q1.size());
            q0.delete(); q3.delete(); q1.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en0 = 1'b1; en3 = 1'b1; en1 = 1'b1;
        moles = 18'h3FFFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({sw0, sw3, sw1} !== '0 || {st0, st3, st1} !== 3'b000 ||
                {c0, c3, c1} !== '0) begin
                errors++;
                $display("FAIL reset_state sw=%h/%h/%h st=%b%b%b cnt=%0d/%0d/%0d need zeros",
                         sw0, sw3, sw1, st0, st3, st1, c0, c3, c1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; en0 = 1'b0; en3 = 1'b0; en1 = 1'b0; moles = '0;
    endtask

    task automatic test_two_moles;
        int t;
        do_reset();
        en0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 moles = 18'h00005; t = cyc;
        q0.push_back('{t + 6, 18'h00001, 16'd1});
        q0.push_back('{t + 10, 18'h00005, 16'd2});
        drain("two_moles");
        checks++;
        if (sw0 !== 18'h00005 || c0 !== 16'd2) begin
            errors++;
            $display("FAIL two_moles_final sw=%h cnt=%0d need sw=00005 cnt=2", sw0, c0);
        end
    endtask

    task automatic test_miss_every3;
        int t;
        do_reset();
        en3 = 1'b1;
        repeat (3) @(posedge clk);
        #1 moles = 18'h00007; t = cyc;
        q3.push_back('{t + 6, 18'h00001, 16'd1});
        q3.push_back('{t + 10, 18'h00003, 16'd2});
        q3.push_back('{t + 14, 18'h0000B, 16'd3});
        q3.push_back('{t + 18, 18'h0000F, 16'd4});
        drain("miss3");
        checks++;
        if (sw3 !== 18'h0000F || c3 !== 16'd4) begin
            errors++;
            $display("FAIL miss3_final sw=%h cnt=%0d need sw=0000f cnt=4", sw3, c3);
        end
    endtask

    task automatic test_mid_react_change;
        int t;
        do_reset();
        en0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 moles = 18'h00001; t = cyc;
        q0.push_back('{t + 10, 18'h00010, 16'd1});
        repeat (4) @(posedge clk);
        #1 moles = 18'h00010;
        drain("mid_react");
        checks++;
        if (sw0 !== 18'h00010 || c0 !== 16'd1) begin
            errors++;
            $display("FAIL mid_react_final sw=%h cnt=%0d need sw=00010 cnt=1", sw0, c0);
        end
    endtask

    task automatic test_enable_drop;
        int t, r;
        do_reset();
        en0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 moles = 18'h00003; t = cyc;
        q0.push_back('{t + 6, 18'h00001, 16'd1});
        repeat (8) @(posedge clk);
        #1 en0 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (sw0 !== 18'h00001 || c0 !== 16'd1) begin
                errors++;
                $display("FAIL enable_drop_frozen sw=%h cnt=%0d need sw=00001 cnt=1", sw0, c0);
            end
        end
        @(posedge clk); #1;
        en0 = 1'b1; r = cyc;
        q0.push_back('{r + 7, 18'h00000, 16'd2});
        q0.push_back('{r + 11, 18'h00002, 16'd3});
        drain("enable_drop");
        checks++;
        if (sw0 !== 18'h00002 || c0 !== 16'd3) begin
            errors++;
            $display("FAIL enable_drop_final sw=%h cnt=%0d need sw=00002 cnt=3", sw0, c0);
        end
    endtask

    task automatic test_miss_every1;
        int t;
        do_reset();
        en1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 moles = 18'h3FFFF; t = cyc;
        q1.push_back('{t + 6, 18'h00001, 16'd1});
        q1.push_back('{t + 14, 18'h00000, 16'd2});
        repeat (8) @(posedge clk);
        #1 moles = 18'h3FFFE;
        repeat (7) @(posedge clk);
        #1 en1 = 1'b0;
        drain("miss1");
        checks++;
        if (sw1 !== 18'h00000 || c1 !== 16'd2) begin
            errors++;
            $display("FAIL miss1_final sw=%h cnt=%0d need sw=00000 cnt=2", sw1, c1);
        end
    endtask

    task automatic test_back_to_back;
        int t;
        exp_t e;
        do_reset();
        en0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 moles = 18'h3FFFF; t = cyc;
        for (int k = 1; k <= 18; k++) begin
            e.cyc = t + 6 + 4 * (k - 1);
            e.sw  = 18'((64'd1 << k) - 64'd1);
            e.cnt = 16'(k);
            q0.push_back(e);
        end
        drain("back_to_back");
        checks++;
        if (sw0 !== 18'h3FFFF || c0 !== 16'd18) begin
            errors++;
            $display("FAIL back_to_back_final sw=%h cnt=%0d need sw=3ffff cnt=18", sw0, c0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_moles();
        test_miss_every3();
        test_mid_react_change();
        test_enable_drop();
        test_miss_every1();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/auto_player.md
Name: auto_player

Overview:
- Demo/attract-mode "player" for the whack-a-mole game: watches mole_positions and drives a switch vector as the player would, after a human-like reaction delay.
- It is the stimulus end of the hit_logic interface and drives the same switch bus that hit_logic samples; top-level muxes it against SW when demo mode is selected.
- A whack is a single-bit toggle of the switch in a hole; deliberate misses exercise the miss/combo-reset path.

Parameters:
- NUM_HOLES, 18, width of mole_positions and switches
- CLKS_PER_MS, 50000, clock cycles per millisecond
- REACTION_MS, 300, delay from new mole pattern to first whack
- SETTLE_MS, 150, hold-off between consecutive whacks
- MISS_EVERY, 5, every Nth whack is aimed at an empty hole; 0 = never miss
- JITTER_MS, 64, max added reaction jitter (used only with the optional feature; power of 2)

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  synchronous, active-high reset
- enable  in  1  game_in_progress; player acts only while high
- mole_positions  in  NUM_HOLES  current mole pattern from mole_generator
- switches  out  NUM_HOLES  registered switch vector to hit_logic
- whack_strobe  out  1  one-cycle pulse in the cycle switches changes
- whack_count  out  16  total whacks issued, saturates at 16'hFFFF

Behaviour:
- Reset: switches=0, whack_strobe=0, whack_count=0, whacked mask=0, miss counter=0, prev_moles=0, state IDLE. rst overrides all other inputs.
- REACT_CLKS = REACTION_MS*CLKS_PER_MS. SETTLE_CLKS = SETTLE_MS*CLKS_PER_MS. Both are computed at elaboration; the delay counter is $clog2(max)+1 bits wide.
- prev_moles registers mole_positions every cycle. A change is mole_positions != prev_moles.
- States:
  - IDLE: entered on reset or when enable=0. Go to WAIT when enable=1.
  - WAIT: if pending != 0, load REACT_CLKS and go to REACT. pending = mole_positions & ~whacked.
  - REACT: count down. At expiry go to WHACK.
  - WHACK: toggle one switch bit, pulse whack_strobe, increment whack_count, set the whacked bit, load SETTLE_CLKS, go to HOLDOFF.
  - HOLDOFF: at expiry, if pending != 0 go directly to WHACK (no new reaction delay); else go to WAIT.
- Target selection in WHACK:
  - Normal: the lowest-index set bit of pending.
  - If MISS_EVERY != 0 and this is the MISS_EVERY-th whack since the last miss: target the lowest-index zero bit of mole_positions, leave the whacked mask unchanged, and reset the miss counter.
  - If mole_positions is all ones on a miss turn, perform a normal hit; the miss counter stays at its due value.
- Latency: a change sampled in cycle t (WAIT state) produces the switches toggle and whack_strobe in cycle t+REACT_CLKS.
- A change in any state other than IDLE clears the whacked mask. In REACT or HOLDOFF it reloads REACT_CLKS and enters REACT. The change has priority over timer expiry in the same cycle.
- enable low in any state: next state is IDLE. switches, whack_count and the miss counter hold; the whacked mask clears.
- whack_strobe is high only in the WHACK cycle. whack_count does not wrap.

Optional Feature:
- Macro AUTO_PLAYER_LFSR_JITTER_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01 on rst) advances every cycle. Each REACT load adds (lfsr % JITTER_MS)*CLKS_PER_MS to REACT_CLKS.
- Undefined: the reaction time is exactly REACT_CLKS and there is no LFSR logic.

Decomposition:
- Shared package whack_a_mole_pkg holds:
  - the state enum (IDLE, WAIT, REACT, WHACK, HOLDOFF)
  - an ms_to_clks constant function
  - a lowest-set-bit priority-encoder function reused by mole_generator/hit_logic
- One natural sub-module, ms_delay_counter: load value, count down, one-cycle done pulse, synchronous reset.

Test Plan:
(Sim parameters: CLKS_PER_MS=2, REACTION_MS=3, SETTLE_MS=2, MISS_EVERY=0 unless stated, so REACT_CLKS=6, SETTLE_CLKS=4.)
1. rst held 3 cycles with enable=1 and moles=18'h3FFFF -> switches=0, strobe=0, count=0 throughout; no toggle until after release.
2. enable=1; moles 0->18'h00005 at cycle t -> bit0 toggles with strobe at t+6, bit2 toggles at t+10, count=2, then WAIT with no further strobes.
3. MISS_EVERY=3; moles=18'h00007 -> toggles in order bit0, bit1, bit3 (miss), bit2; count=4.
4. moles=18'h00001, then changed to 18'h00010 at t+4 (mid-REACT) -> no toggle at t+6; bit4 toggles at t+10.
5. enable dropped during HOLDOFF -> IDLE next cycle; switches and count frozen; re-enable with the same moles -> all mole holes whacked again after 6 cycles.
6. MISS_EVERY=1; moles=18'h3FFFF -> first whack toggles bit0 (forced hit); with moles=18'h3FFFE the next whack toggles bit0 as a miss.
